// File: rtl/j_power_pkg.sv
// Shared types and helpers for the max-power
// stress harness receive-side checker.
package j_power_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    DONE
  } sig_state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

  // Phase counter counts down from (len-1), so
  // $clog2(len) bits suffice; never narrower than 1.
  function automatic int phase_width(
    input int warm,
    input int win
  );
    int m;
    m = (warm > win) ? warm : win;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/j_misr.sv
// Single-input MISR: shift left, poly feedback
// from the MSB, data bit folded into the LSB.
module j_misr
  import j_power_pkg::*;
#(
  parameter int SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY =
    DEFAULT_POLY[SIG_WIDTH-1:0],
  parameter logic [SIG_WIDTH-1:0] SEED = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic                 din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] fb;
  logic [SIG_WIDTH-1:0] step;

  assign fb   = sig[SIG_WIDTH-1] ? POLY : '0;
  assign step = {sig[SIG_WIDTH-2:0], 1'b0}
              ^ fb
              ^ {{(SIG_WIDTH-1){1'b0}}, din};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift_en) begin
      sig <= step;
    end
  end

endmodule

// File: rtl/j_result_signature.sv
// Compacts the wrapper result stream into a MISR
// signature over a fixed window, with activity counts.
module j_result_signature
  import j_power_pkg::*;
#(
  parameter int SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY =
    DEFAULT_POLY[SIG_WIDTH-1:0],
  parameter logic [SIG_WIDTH-1:0] SEED = '1,
  parameter int WARMUP_CYCLES = 2,
  parameter int WINDOW_CYCLES = 4096,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 result_xor,
  input  logic                 result_en_xor,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_WIDTH-1:0] en_count,
  output logic [CNT_WIDTH-1:0] toggle_count,
  output logic                 busy,
  output logic                 done,
  output logic                 match
);

  localparam int PW =
    phase_width(WARMUP_CYCLES, WINDOW_CYCLES);
  localparam logic [PW-1:0] WARM_LAST =
    PW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] WIN_LAST =
    PW'(WINDOW_CYCLES - 1);

  sig_state_t           state;
  logic [PW-1:0]        phase;
  logic                 prev_xor;
  logic                 first;
  logic                 match_q;
  logic                 start_ok;
  logic                 sample;
  logic [SIG_WIDTH-1:0] sig_step;
  logic [SIG_WIDTH-1:0] sig_next;

  assign start_ok = start
                  && (state == IDLE || state == DONE);
  assign sample   = (state == COLLECT);

  j_misr #(
    .SIG_WIDTH(SIG_WIDTH),
    .POLY     (POLY),
    .SEED     (SEED)
  ) u_misr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .shift_en(sample && result_en_xor),
    .din     (result_xor),
    .sig     (signature)
  );

  // Mirror of the MISR step so match sees the final sample.
  assign sig_step = {signature[SIG_WIDTH-2:0], 1'b0}
                  ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                  ^ {{(SIG_WIDTH-1){1'b0}}, result_xor};
  assign sig_next = result_en_xor ? sig_step : signature;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      phase        <= '0;
      prev_xor     <= 1'b0;
      first        <= 1'b0;
      en_count     <= '0;
      toggle_count <= '0;
      match_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            en_count     <= '0;
            toggle_count <= '0;
            match_q      <= 1'b0;
            first        <= 1'b1;
            if (WARMUP_CYCLES == 0) begin
              state <= COLLECT;
              phase <= WIN_LAST;
            end else begin
              state <= WARMUP;
              phase <= WARM_LAST;
            end
          end
        end
        WARMUP: begin
          if (phase == '0) begin
            state <= COLLECT;
            phase <= WIN_LAST;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        COLLECT: begin
          if (result_en_xor && en_count != '1)
            en_count <= en_count + 1'b1;
          if (!first && result_xor != prev_xor
              && toggle_count != '1)
            toggle_count <= toggle_count + 1'b1;
          prev_xor <= result_xor;
          first    <= 1'b0;
          if (phase == '0) begin
            state   <= DONE;
            match_q <= (sig_next == expected_sig);
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == WARMUP) || (state == COLLECT);
  assign done  = (state == DONE);
  assign match = match_q;

endmodule

// File: tb/tb_j_result_signature.sv
// Randomized and directed bench for j_result_signature,
// four configurations driven by one shared stream.
module tb_j_result_signature;

  localparam int LAST = 53;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic rx = 1'b0;
  logic ren = 1'b0;

  logic [7:0]  exp_a, exp_b, exp_c;
  logic [31:0] exp_d;
  logic [7:0]  sig_a, sig_b, sig_c;
  logic [31:0] sig_d;
  logic [15:0] en_a, tg_a, en_b, tg_b, en_d, tg_d;
  logic [1:0]  en_c, tg_c;
  logic busy_a, done_a, match_a;
  logic busy_b, done_b, match_b;
  logic busy_c, done_c, match_c;
  logic busy_d, done_d, match_d;

  logic s_en [0:79];
  logic s_x  [0:79];

  logic [31:0] ea, eb, ec, ed;
  logic [15:0] ena, tga, enb, tgb, enc, tgc, endd, tgd;
  logic ma, mb, mc, md;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  j_result_signature #(
    .SIG_WIDTH(8), .POLY(8'h07), .SEED(8'hFF),
    .WARMUP_CYCLES(0), .WINDOW_CYCLES(4),
    .CNT_WIDTH(16)
  ) u_a (
    .clk(clk), .reset(reset), .start(start),
    .result_xor(rx), .result_en_xor(ren),
    .expected_sig(exp_a), .signature(sig_a),
    .en_count(en_a), .toggle_count(tg_a),
    .busy(busy_a), .done(done_a), .match(match_a)
  );

  j_result_signature #(
    .SIG_WIDTH(8), .POLY(8'h07), .SEED(8'hFF),
    .WARMUP_CYCLES(2), .WINDOW_CYCLES(4),
    .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .reset(reset), .start(start),
    .result_xor(rx), .result_en_xor(ren),
    .expected_sig(exp_b), .signature(sig_b),
    .en_count(en_b), .toggle_count(tg_b),
    .busy(busy_b), .done(done_b), .match(match_b)
  );

  j_result_signature #(
    .SIG_WIDTH(8), .POLY(8'h07), .SEED(8'hFF),
    .WARMUP_CYCLES(0), .WINDOW_CYCLES(6),
    .CNT_WIDTH(2)
  ) u_c (
    .clk(clk), .reset(reset), .start(start),
    .result_xor(rx), .result_en_xor(ren),
    .expected_sig(exp_c), .signature(sig_c),
    .en_count(en_c), .toggle_count(tg_c),
    .busy(busy_c), .done(done_c), .match(match_c)
  );

  j_result_signature #(
    .WARMUP_CYCLES(3), .WINDOW_CYCLES(50)
  ) u_d (
    .clk(clk), .reset(reset), .start(start),
    .result_xor(rx), .result_en_xor(ren),
    .expected_sig(exp_d), .signature(sig_d),
    .en_count(en_d), .toggle_count(tg_d),
    .busy(busy_d), .done(done_d), .match(match_d)
  );

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] want
  );
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h",
                  tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sample k is the k-th edge after start;
  // samples w+1..w+n form the window.
  function automatic logic [31:0] m_sig(
    input int sw, input logic [31:0] poly,
    input int w, input int n
  );
    logic [31:0] mask;
    logic [31:0] s;
    logic msb;
    mask = (sw == 32) ? 32'hFFFF_FFFF
                      : ((32'd1 << sw) - 32'd1);
    s = mask;
    for (int k = w + 1; k <= w + n; k++) begin
      if (s_en[k]) begin
        msb = s[sw-1];
        s = ((s << 1) ^ (msb ? poly : 32'd0)
             ^ {31'd0, s_x[k]}) & mask;
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] m_en(
    input int w, input int n, input int cw
  );
    int c;
    int top;
    top = (1 << cw) - 1;
    c = 0;
    for (int k = w + 1; k <= w + n; k++)
      if (s_en[k] && c < top) c++;
    return 16'(c);
  endfunction

  function automatic logic [15:0] m_tog(
    input int w, input int n, input int cw
  );
    int c;
    int top;
    top = (1 << cw) - 1;
    c = 0;
    for (int k = w + 2; k <= w + n; k++)
      if (s_x[k] != s_x[k-1] && c < top) c++;
    return 16'(c);
  endfunction

  function automatic logic [31:0] pick_exp(
    input int mode, input logic [31:0] e,
    input logic [31:0] mask
  );
    if (mode == 1) return e;
    if (mode == 2) return 32'd0;
    if ($urandom_range(0, 1) == 1) return e;
    return (e ^ 32'd1) & mask;
  endfunction

  task automatic gen_random();
    for (int k = 0; k < 80; k++) begin
      s_en[k] = 1'($urandom);
      s_x[k]  = 1'($urandom);
    end
  endtask

  task automatic gen_fixed(
    input logic en, input logic x0, input logic alt
  );
    for (int k = 0; k < 80; k++) begin
      s_en[k] = en;
      s_x[k]  = alt ? (x0 ^ k[0]) : x0;
    end
  endtask

  task automatic edge_checks(input int k);
    if (k >= 1 && k <= 4)
      chk("a_sig_run", sig_a, m_sig(8, 8'h07, 0, k));
    if (k == 3) begin
      chk("a_busy_pre", busy_a, 1); chk("a_done_pre", done_a, 0);
    end
    if (k == 4 || k == LAST) begin
      chk("a_busy", busy_a, 0); chk("a_done", done_a, 1);
      chk("a_sig", sig_a, ea); chk("a_en", en_a, ena);
      chk("a_tog", tg_a, tga); chk("a_match", match_a, ma);
    end
    if (k == 5) begin
      chk("b_busy_pre", busy_b, 1); chk("b_done_pre", done_b, 0);
      chk("c_busy_pre", busy_c, 1); chk("c_done_pre", done_c, 0);
    end
    if (k == 6) begin
      chk("b_busy", busy_b, 0); chk("b_done", done_b, 1);
      chk("b_sig", sig_b, eb); chk("b_en", en_b, enb);
      chk("b_tog", tg_b, tgb); chk("b_match", match_b, mb);
      chk("c_busy", busy_c, 0); chk("c_done", done_c, 1);
      chk("c_sig", sig_c, ec); chk("c_en", en_c, enc);
      chk("c_tog", tg_c, tgc); chk("c_match", match_c, mc);
    end
    if (k == LAST - 1) begin
      chk("d_busy_pre", busy_d, 1); chk("d_done_pre", done_d, 0);
    end
    if (k == LAST) begin
      chk("d_busy", busy_d, 0); chk("d_done", done_d, 1);
      chk("d_sig", sig_d, ed); chk("d_en", en_d, endd);
      chk("d_tog", tg_d, tgd); chk("d_match", match_d, md);
    end
  endtask

  task automatic run(input int mode, input int restart_at);
    ea = m_sig(8, 32'h07, 0, 4);
    eb = m_sig(8, 32'h07, 2, 4);
    ec = m_sig(8, 32'h07, 0, 6);
    ed = m_sig(32, 32'h04C11DB7, 3, 50);
    ena = m_en(0, 4, 16);  tga = m_tog(0, 4, 16);
    enb = m_en(2, 4, 16);  tgb = m_tog(2, 4, 16);
    enc = m_en(0, 6, 2);   tgc = m_tog(0, 6, 2);
    endd = m_en(3, 50, 16); tgd = m_tog(3, 50, 16);
    exp_a = 8'(pick_exp(mode, ea, 32'hFF));
    exp_b = 8'(pick_exp(mode, eb, 32'hFF));
    exp_c = 8'(pick_exp(mode, ec, 32'hFF));
    exp_d = pick_exp(mode, ed, 32'hFFFF_FFFF);
    ma = (exp_a == ea[7:0]);
    mb = (exp_b == eb[7:0]);
    mc = (exp_c == ec[7:0]);
    md = (exp_d == ed);
    start = 1'b1;
    ren = 1'($urandom);
    rx = 1'($urandom);
    tick();
    for (int k = 1; k <= LAST; k++) begin
      start = (k == restart_at);
      ren = s_en[k];
      rx = s_x[k];
      tick();
      edge_checks(k);
    end
    start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_sig"}, sig_a, 8'hFF);
    chk({tag, "_a_en"}, en_a, 0);
    chk({tag, "_a_tog"}, tg_a, 0);
    chk({tag, "_a_busy"}, busy_a, 0);
    chk({tag, "_a_done"}, done_a, 0);
    chk({tag, "_a_match"}, match_a, 0);
    chk({tag, "_d_sig"}, sig_d, 32'hFFFF_FFFF);
    chk({tag, "_d_busy"}, busy_d, 0);
    chk({tag, "_c_en"}, en_c, 0);
  endtask

  initial begin
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    gen_random();
    tick();
    tick();
    reset_checks("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Window of en=1, xor=0: F9 F5 ED DD.
    gen_fixed(1'b1, 1'b0, 1'b0);
    run(1, 0);
    chk("s1_sig", sig_a, 8'hDD);
    chk("s1_match", match_a, 1);
    chk("s1_en", en_a, 4);
    chk("s1_tog", tg_a, 0);
    run(2, 0);
    chk("s2_nomatch", match_a, 0);

    gen_random();
    s_en[1] = 1'b1; s_x[1] = 1'b1;
    s_en[2] = 1'b0; s_x[2] = 1'b0;
    s_en[3] = 1'b0; s_x[3] = 1'b1;
    s_en[4] = 1'b0; s_x[4] = 1'b0;
    run(0, 0);
    chk("s3_sig", sig_a, 8'hF8);
    chk("s3_en", en_a, 1);
    chk("s3_tog", tg_a, 3);

    gen_fixed(1'b1, 1'b1, 1'b0);
    run(0, 0);
    chk("s4_en", en_b, 4);

    gen_random();
    run(0, 2);

    // Abort mid-window, then a clean repeat.
    gen_fixed(1'b1, 1'b0, 1'b0);
    start = 1'b1; tick();
    start = 1'b0; ren = 1'b1; rx = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    reset_checks("abort");
    @(negedge clk);
    reset = 1'b1;
    tick();
    run(1, 0);
    chk("s5_sig", sig_a, 8'hDD);

    gen_fixed(1'b1, 1'b0, 1'b1);
    run(0, 0);
    chk("s6_en_sat", en_c, 3);
    chk("s6_tog_sat", tg_c, 3);

    for (int i = 0; i < 6; i++) begin
      gen_random();
      run(0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/j_result_signature.md
Name: j_result_signature

Overview:
- Receive-side checker for the max-power stress harness.
- Consumes the single-bit `result_xor` / `result_en_xor` stream produced by `j_max_power_wrapper`.
- Compacts the stream into a MISR signature over a fixed window, counts enable-active and toggle cycles, then compares the signature against an expected value.
- Sits next to the wrapper, so silicon or emulation runs give a pass/fail result and an activity measure instead of a waveform dump.

Parameters:
- SIG_WIDTH, 32, MISR/signature width (>=4).
- POLY, 32'h04C11DB7, feedback polynomial, truncated to SIG_WIDTH.
- SEED, all ones, signature value loaded on start.
- WARMUP_CYCLES, 2, cycles ignored after start for wrapper pipeline fill (0 allowed).
- WINDOW_CYCLES, 4096, number of sampled cycles (>=1).
- CNT_WIDTH, 16, width of activity counters.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a measurement.
- result_xor, input, 1, XOR-reduced array result bit.
- result_en_xor, input, 1, XOR-reduced result-enable bit.
- expected_sig, input, SIG_WIDTH, golden signature; sampled at DONE entry.
- signature, output, SIG_WIDTH, current MISR value.
- en_count, output, CNT_WIDTH, sampled cycles with result_en_xor=1.
- toggle_count, output, CNT_WIDTH, sampled cycles where result_xor differs from the previous sampled value.
- busy, output, 1, high in WARMUP or COLLECT.
- done, output, 1, level; high in DONE.
- match, output, 1, registered (signature == expected_sig); valid when done=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, signature=SEED, counters=0, busy=0, done=0, match=0, prev_xor=0.
- States: IDLE, WARMUP, COLLECT, DONE.
- start in IDLE or DONE:
  - Load signature=SEED, clear en_count/toggle_count, clear done/match.
  - Go to WARMUP, or straight to COLLECT if WARMUP_CYCLES=0.
  - Load the phase counter.
- start in WARMUP or COLLECT is ignored; there is no restart mid-window.
- WARMUP: lasts exactly WARMUP_CYCLES cycles. Inputs are ignored; signature is held.
- COLLECT: lasts exactly WINDOW_CYCLES cycles, one sample per rising edge.
  - With WARMUP_CYCLES=0, the first sample is taken at the edge after the edge that captured start.
- MISR update when result_en_xor=1:
  - sig_next = (sig<<1, truncated) ^ (sig[MSB] ? POLY : 0) ^ {0..0, result_xor}.
  - When result_en_xor=0, the signature holds.
- en_count increments on sampled en=1.
- toggle_count increments on sampled result_xor != prev_xor.
  - prev_xor is loaded from the first sample; the first sample never counts as a toggle.
- Both counters saturate at all ones; there is no wrap.
- At the edge taking the last COLLECT sample:
  - The signature includes that sample.
  - The state moves to DONE.
  - match is computed on that edge from the final sig_next and expected_sig.
- done=1 in the cycle after the last sample edge, and from that cycle on.
  - Total latency from the start edge to done high = WARMUP_CYCLES + WINDOW_CYCLES + 1 edges.
- DONE: all outputs hold until the next start or reset.
- busy = (state==WARMUP or COLLECT), decoded from registered state.
- Reset asserted mid-window aborts the measurement; all outputs return to reset values, with no partial done.
- Inputs are synchronous to clk; no synchronizers.

Decomposition:
- Package j_power_pkg:
  - state enum `sig_state_t` {IDLE, WARMUP, COLLECT, DONE}.
  - Default POLY constant.
  - Counter-width helper (`$clog2`-based) for the phase counter, sized to max(WARMUP_CYCLES, WINDOW_CYCLES).
- One natural sub-module: j_misr.
  - Parameterised SIG_WIDTH/POLY/SEED.
  - Ports: clk, reset, load, shift_en, din, sig.
- FSM and counters stay in j_result_signature.

Test Plan:
1. SIG_WIDTH=8, POLY=8'h07, SEED=8'hFF, WARMUP=0, WINDOW=4; start, then en=1, xor=0 for 4 cycles -> signature F9,F5,ED,DD; done high after 5th edge; en_count=4; toggle_count=0.
2. Same config, expected_sig=8'hDD -> match=1. Repeat with expected_sig=8'h00 -> match=0.
3. Same config, sample 1: en=1, xor=1; samples 2-4: en=0, xor alternating 0,1,0 -> final signature F8; en_count=1; toggle_count=3.
4. WARMUP=2, WINDOW=4, en=1, xor=1 held from start -> first two cycles ignored; busy high for 6 cycles; done at edge 7; en_count=4.
5. Pulse start again mid-COLLECT -> ignored, done timing unchanged. Assert reset at sample 2 -> signature=FF, counters=0, done=0, state IDLE; a fresh start then reproduces scenario 1.
6. CNT_WIDTH=2, WINDOW=6, en=1 and xor toggling every cycle -> en_count and toggle_count both saturate at 3 with no wrap.
